// File: rtl/cn_msg_gen.sv
// Check-node message generator for the min-sum LDPC decoder.
// Expands a captured {min, min2, min_idx, sign} result into D signed messages, one per handshake.
module cn_msg_gen #(
  parameter int data_w = 8,
  parameter int idx_w  = 8,
  parameter int D      = 5,
  parameter int OFFSET = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [data_w-1:0] min,
  input  logic [data_w-1:0] min2,
  input  logic [idx_w-1:0]  min_idx,
  input  logic [D-1:0]      sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w:0]   out_msg,
  output logic [idx_w-1:0]  out_idx,
  output logic              out_last
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [data_w-1:0] OFF      = data_w'(OFFSET);
  localparam logic [idx_w-1:0]  DEG      = idx_w'(D);
  localparam logic [idx_w-1:0]  LAST_IDX = idx_w'(D - 1);

  state_t                  state_q, state_d;
  logic [data_w-1:0]       min_q, min_d;
  logic [data_w-1:0]       min2_q, min2_d;
  logic [idx_w-1:0]        min_idx_q, min_idx_d;
  logic [D-1:0]            sign_q, sign_d;
  logic                    parity_q, parity_d;
  logic [idx_w-1:0]        out_idx_q, out_idx_d;
  logic signed [data_w:0]  out_msg_q, out_msg_d;
  logic                    accept;
  logic                    advance;

  // Offset correction clamps at zero instead of wrapping.
  function automatic logic [data_w-1:0] sat_sub(input logic [data_w-1:0] m);
    return (m > OFF) ? m - OFF : '0;
  endfunction

  // An out-of-range min_idx (padding for odd degree) makes every edge use min.
  function automatic logic signed [data_w:0] edge_msg(
    input logic [idx_w-1:0]  k,
    input logic [data_w-1:0] mn,
    input logic [data_w-1:0] mn2,
    input logic [idx_w-1:0]  midx,
    input logic [D-1:0]      sgn,
    input logic              par
  );
    logic [data_w-1:0] mag;
    logic [D-1:0]      sh;
    logic              neg;
    mag = ((midx < DEG) && (k == midx)) ? mn2 : mn;
    mag = sat_sub(mag);
    sh  = sgn >> k;
    neg = par ^ sh[0];
    return neg ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  assign out_valid = (state_q == EMIT);
  assign out_last  = out_valid && (out_idx_q == LAST_IDX);
  assign in_ready  = (state_q == IDLE) || (out_valid && out_ready && out_last);
  assign accept    = in_valid && in_ready;
  assign advance   = out_valid && out_ready;
  assign out_msg   = out_msg_q;
  assign out_idx   = out_idx_q;

  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    min2_d    = min2_q;
    min_idx_d = min_idx_q;
    sign_d    = sign_q;
    parity_d  = parity_q;
    out_idx_d = out_idx_q;
    out_msg_d = out_msg_q;
    if (accept) begin
      min_d     = min;
      min2_d    = min2;
      min_idx_d = min_idx;
      sign_d    = sign;
      parity_d  = ^sign;
      out_idx_d = '0;
      out_msg_d = edge_msg('0, min, min2, min_idx, sign, ^sign);
      state_d   = EMIT;
    end else if (advance) begin
      if (out_last) begin
        out_idx_d = '0;
        out_msg_d = '0;
        state_d   = IDLE;
      end else begin
        out_idx_d = out_idx_q + idx_w'(1);
        out_msg_d = edge_msg(out_idx_q + idx_w'(1), min_q, min2_q, min_idx_q, sign_q, parity_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      min_q     <= '0;
      min2_q    <= '0;
      min_idx_q <= '0;
      sign_q    <= '0;
      parity_q  <= 1'b0;
      out_idx_q <= '0;
      out_msg_q <= '0;
    end else begin
      state_q   <= state_d;
      min_q     <= min_d;
      min2_q    <= min2_d;
      min_idx_q <= min_idx_d;
      sign_q    <= sign_d;
      parity_q  <= parity_d;
      out_idx_q <= out_idx_d;
      out_msg_q <= out_msg_d;
    end
  end

endmodule
